// File: rtl/uart_rx_frame_driver.sv
// uart_rx_frame_driver: parametrised UART receiver (data width, parity, stop bits).
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each bit mid-point.
module uart_rx_frame_driver #(
  parameter int CYCLES_PER_BIT = 16,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] out,
  output logic                 outclk,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = CYCLES_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = M + 1;
`else
  localparam int DEC = M;
`endif

  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(DEC);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [BW-1:0]        bitc;
  logic [BW-1:0]        bit_n;
  logic                 stp;
  logic                 stp_n;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] sh_n;
  logic                 pb;
  logic                 pb_n;

  logic                 s1;
  logic                 rs;
  logic                 rs_d;
  logic [1:0]           vld;
  logic                 armed;
  logic                 fall;

  logic                 tick;
  logic                 dec_bit;
  logic                 done;
  logic                 ferr;
  logic                 perr;

  // Synchroniser; armed only once the real line has been seen high
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      rs    <= 1'b1;
      rs_d  <= 1'b1;
      vld   <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1    <= rxd;
      rs    <= s1;
      rs_d  <= rs;
      vld   <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & rs);
    end
  end

  assign fall = armed & rs_d & ~rs;

`ifdef UART_RX_MAJORITY_EN
  logic v0;
  logic v1;

  // Capture the two samples ahead of the voting cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (cnt == CW'(M - 1)) v0 <= rs;
      if (cnt == CW'(M))     v1 <= rs;
    end
  end

  assign dec_bit = (v0 & v1) | (v0 & rs) | (v1 & rs);
`else
  assign dec_bit = rs;
`endif

  assign tick = (state != IDLE) &&
                (state != BREAK) &&
                (cnt == CNT_DEC);

  assign busy = (state != IDLE);

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bitc  <= '0;
      stp   <= 1'b0;
      sh    <= '0;
      pb    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitc  <= bit_n;
      stp   <= stp_n;
      sh    <= sh_n;
      pb    <= pb_n;
    end
  end

  // Next state: bit decisions are taken at a fixed phase of cnt
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bitc;
    stp_n   = stp;
    sh_n    = sh;
    pb_n    = pb;
    done    = 1'b0;
    ferr    = 1'b0;
    if (state != IDLE && state != BREAK) begin
      cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) begin
          state_n = START;
          cnt_n   = CW'(1);
        end
      end
      START: begin
        if (tick) begin
          if (dec_bit) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            bit_n   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_n  = {dec_bit, sh[DATA_BITS-1:1]};
          bit_n = bitc + BW'(1);
          if (bitc == BIT_LAST) begin
            state_n = (PARITY != 0) ? PAR : STOP;
            stp_n   = 1'b0;
          end
        end
      end
      PAR: begin
        if (tick) begin
          pb_n    = dec_bit;
          state_n = STOP;
          stp_n   = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (!dec_bit) begin
            done    = 1'b1;
            ferr    = 1'b1;
            state_n = BREAK;
          end else if (stp == STP_LAST) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            stp_n = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Parity check over the received word plus parity bit
  always_comb begin
    perr = 1'b0;
    if (PARITY == 1) perr = ~(^sh ^ pb);
    else if (PARITY == 2) perr = ^sh ^ pb;
  end

  // Registered word, strobe and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      outclk     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      outclk <= done;
      if (done) begin
        out        <= sh;
        parity_err <= perr;
        frame_err  <= ferr;
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_driver.md
# uart_rx_frame_driver

Parametrised single-clock UART receiver, successor to the fixed 8N1 receive path. It supports configurable data width, optional odd/even parity, one or two stop bits, and any oversampling ratio. It reports framing and parity errors alongside each received word and rejects glitch start bits. It sits directly behind the board RX pin and feeds byte-stream consumers in the system clock domain, so no clock-crossing FIFO is needed.

## Interface
- CYCLES_PER_BIT, 16, clk cycles per bit period; legal ≥ 4.
- DATA_BITS, 8, data bits per frame; legal 5..9; received LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- clk  in  1  system clock; one clock only.
- reset  in  1  synchronous, active-high.
- rxd  in  1  asynchronous serial line, idle high.
- out  out  DATA_BITS  received word; valid from the outclk cycle and held until the next outclk.
- outclk  out  1  one-cycle pulse: new frame on out.
- parity_err  out  1  parity mismatch for the current out; 0 when PARITY = 0; updated only with outclk.
- frame_err  out  1  stop bit sampled low for the current out; updated only with outclk.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- rxd passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised line, rs, and its previous value, rs_d.
- States: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE:
  - On rs_d = 1 and rs = 0, go to START with bit counter cnt = 0. That edge cycle is cnt 0.
  - A line held low out of reset does not start a frame.
- cnt runs 0..CYCLES_PER_BIT−1 in each bit period, then wraps and advances the bit index.
- Sample decision: value of rs at cnt = CYCLES_PER_BIT/2 (integer division), called the mid-point.
- START: if the mid-point decision is 1, the start is false. Return to IDLE with no outclk.
- DATA: shift DATA_BITS decisions in LSB first. Then go to PAR if PARITY ≠ 0, else STOP.
- PAR: the parity error condition is:
  - odd: XOR of data bits and parity bit = 0.
  - even: XOR of data bits and parity bit = 1.
- STOP:
  - Each stop-bit decision must be 1.
  - On the final stop decision at 1: issue outclk and go straight to IDLE. This resynchronises in the second half of the stop bit, which tolerates a fast transmitter.
  - On any stop decision at 0: issue outclk immediately with frame_err = 1 and go to BREAK. Any remaining stop bit is skipped.
- BREAK: wait until rs = 1, then go to IDLE. No outclk is issued during the break.
- Reset mid-frame aborts the frame with no outclk and returns to IDLE.
- Reset values: out = 0, outclk = 0, parity_err = 0, frame_err = 0, busy = 0.

## Timing
- The decision for frame bit k is taken at cycle k·CYCLES_PER_BIT + CYCLES_PER_BIT/2 after the start edge cycle.
  - k = 0 is the start bit; data, parity and stop bits follow in order.
- outclk, out and the error flags are registered. They assert one cycle after the final decision.
- rxd-to-rs latency is 2 cycles.
- Total, CYCLES_PER_BIT = 16, 8N1: outclk is high 155 cycles after rxd first goes low.
  - 2 cycles synchroniser + 9·16 + 8 to the final decision + 1 register.
- busy rises the cycle after the start edge. It falls the cycle the FSM re-enters IDLE.
- Back-to-back frames with no idle gap are received without loss.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each decision is the 2-of-3 majority of rs at cnt = M−1, M and M+1, where M = CYCLES_PER_BIT/2.
  - The decision is taken at cnt = M+1, so every decision and outclk moves one cycle later. The 8N1/16 total becomes 156 cycles.
  - False-start rejection uses the same vote.
- Undefined: a single sample at cnt = M, with the timing given above.

## Test plan
- 8N1, CYCLES_PER_BIT = 16, send 0x55 → outclk 155 cycles after the falling edge, out = 0x55, both errors 0.
- 8E1, send 0xA5 with parity bit 1 (correct is 0) → outclk, out = 0xA5, parity_err = 1. Then send 0x3C with correct parity → parity_err returns to 0.
- 8N1, hold rxd low for 20 bit periods after a start bit → one outclk with out = 0x00 and frame_err = 1. busy stays high until rxd rises. Then send 0x81 → out = 0x81, frame_err = 0.
- Pulse rxd low for 4 cycles while idle → busy high for 8 cycles then low, no outclk.
- Assert reset mid-way through data bit 3 → no outclk, busy = 0 the next cycle. Then send 0xF0 → out = 0xF0.
- Inject a 1-cycle inverted glitch at the mid-point of data bit 2 while sending 0x00 →
  - with UART_RX_MAJORITY_EN: out = 0x00.
  - without UART_RX_MAJORITY_EN: out = 0x04.
